// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared response codes, FSM state types and address decode for the register slave
package axi_lite_pkg;
  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef struct packed {
    logic        err;
    logic [29:0] idx;
  } dec_t;
  function automatic dec_t addr_decode(input logic [31:0] addr, input int unsigned num_regs);
    logic [31:0] w;
    w = addr >> 2;
    return '{err: (addr[1:0] != 2'b0) || (w >= num_regs), idx: w[29:0]};
  endfunction
endpackage

// File: rtl/axi_lite_reg_array.sv
// axi_lite_reg_array: byte-enabled register storage with one write port and a registered read port
module axi_lite_reg_array #(
  parameter int DW = 32,
  parameter int NUM_REGS = 8,
  parameter int IW = 3
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IW-1:0]   widx,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            re,
  input  logic            rzero,
  input  logic [IW-1:0]   ridx,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem_q [NUM_REGS];
  logic [DW-1:0] mem_d [NUM_REGS];
  logic [DW-1:0] rdata_q, rdata_d;
  // reads sample mem_q, so a same-edge write is not visible to the read
  always_comb begin
    mem_d = mem_q;
    for (int r = 0; r < NUM_REGS; r++)
      for (int b = 0; b < DW/8; b++)
        if (we && widx == IW'(r) && wstrb[b]) mem_d[r][8*b +: 8] = wdata[8*b +: 8];
    rdata_d = re ? (rzero ? '0 : mem_q[ridx]) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register bank with independent write (AW/W/B) and read (AR/R) engines
module axi_lite_reg_slave import axi_lite_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS = 8
)(
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic                    s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic                    s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  wr_state_t wr_q, wr_d;
  rd_state_t rd_q, rd_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic bresp_q, bresp_d, rresp_q, rresp_d;
  logic aw_hs, w_hs, ar_hs, commit;
  dec_t wdec, rdec;
  logic unused_idx;
  // the *_d holding values double as the commit operands when a handshake completes the pair
  always_comb begin
    aw_hs     = s0_axi_awvalid && awready_q;
    w_hs      = s0_axi_wvalid && wready_q;
    ar_hs     = s0_axi_arvalid && arready_q;
    awaddr_d  = aw_hs ? s0_axi_awaddr : awaddr_q;
    wdata_d   = w_hs ? s0_axi_wdata : wdata_q;
    wstrb_d   = w_hs ? s0_axi_wstrb : wstrb_q;
    commit    = wr_q == WR_IDLE && (aw_held_q || aw_hs) && (w_held_q || w_hs);
    wdec      = addr_decode(32'(awaddr_d), NUM_REGS);
    rdec      = addr_decode(32'(s0_axi_araddr), NUM_REGS);
    aw_held_d = (aw_held_q || aw_hs) && !commit;
    w_held_d  = (w_held_q || w_hs) && !commit;
    wr_d      = commit ? WR_RESP : (wr_q == WR_RESP && s0_axi_bready) ? WR_IDLE : wr_q;
    bresp_d   = commit ? (wdec.err ? RESP_SLVERR : RESP_OKAY) : bresp_q;
    awready_d = !aw_held_d && wr_d == WR_IDLE;
    wready_d  = !w_held_d && wr_d == WR_IDLE;
    rd_d      = ar_hs ? RD_DATA : (rd_q == RD_DATA && s0_axi_rready) ? RD_IDLE : rd_q;
    rresp_d   = ar_hs ? (rdec.err ? RESP_SLVERR : RESP_OKAY) : rresp_q;
    arready_d = rd_d == RD_IDLE;
  end
  always_ff @(posedge s0_axi_aclk) begin
    if (!s0_axi_aresetn) begin
      wr_q      <= WR_IDLE;
      rd_q      <= RD_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
    end
  end
  axi_lite_reg_array #(.DW(DATA_WIDTH), .NUM_REGS(NUM_REGS), .IW(IW)) u_regs (
    .clk   (s0_axi_aclk),
    .rst_n (s0_axi_aresetn),
    .we    (commit && !wdec.err),
    .widx  (wdec.idx[IW-1:0]),
    .wdata (wdata_d),
    .wstrb (wstrb_d),
    .re    (ar_hs),
    .rzero (rdec.err),
    .ridx  (rdec.idx[IW-1:0]),
    .rdata (s0_axi_rdata)
  );
  assign unused_idx     = ^{wdec.idx, rdec.idx};
  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_arready = arready_q;
  assign s0_axi_bvalid  = wr_q == WR_RESP;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_rvalid  = rd_q == RD_DATA;
  assign s0_axi_rresp   = rresp_q;
endmodule
